// File: rtl/div241_pkg.sv
// Shared constants and FSM state type for the streaming divide-by-241 engine.
package div241_pkg;

    localparam int unsigned DIVISOR = 241;
    localparam int unsigned DIGIT_W = 28;
    localparam int unsigned REM_W   = 8;
    localparam int unsigned CORE_W  = 36;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

endpackage

// File: rtl/div_36_241.sv
// Combinational core: divides a 36-bit X by 241, returning a 29-bit quotient indexed [29:1]
// (Q[29] flags a quotient that does not fit the 28-bit digit) and an 8-bit remainder.
module div_36_241
    import div241_pkg::*;
(
    input  logic [CORE_W-1:0]  x,
    output logic [DIGIT_W+1:1] q,
    output logic [REM_W-1:0]   r
);

    logic [CORE_W-1:0] q_full;

    always_comb begin
        q_full = x / CORE_W'(DIVISOR);
        // Fold every bit above the digit into Q[29] so any oversized quotient is flagged.
        q      = {|q_full[CORE_W-1:DIGIT_W], q_full[DIGIT_W-1:0]};
        r      = REM_W'(x % CORE_W'(DIVISOR));
    end

endmodule

// File: rtl/div241_stream.sv
// Streaming long-division engine: MS-first 28-bit dividend digits in, quotient digits out,
// final remainder attached to the last output digit. One digit per cycle, registered output.
module div241_stream
    import div241_pkg::*;
#(
    parameter int unsigned DIGIT_W = 28,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIGIT_W-1:0] out_q,
    output logic [CNT_W-1:0]   out_idx,
    output logic               out_last,
    output logic [7:0]         out_rem,
    output logic               err_ovf
);

    logic [DIGIT_W+1:1] core_q;
    logic [7:0]         core_r;

    state_e             state_q, state_d;
    logic [7:0]         rem_q, rem_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [DIGIT_W-1:0] out_q_q, out_q_d;
    logic [CNT_W-1:0]   out_idx_q, out_idx_d;
    logic               out_last_q, out_last_d;
    logic [7:0]         out_rem_q, out_rem_d;
    logic               err_q, err_d;
    logic               accept;

    div_36_241 u_core (
        .x (CORE_W'({rem_q, in_data})),
        .q (core_q),
        .r (core_r)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_q_d     = out_q_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        out_rem_d   = out_rem_q;
        err_d       = err_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_q_d     = core_q[DIGIT_W:1];
            out_idx_d   = idx_q;
            out_last_d  = in_last;
            out_rem_d   = in_last ? core_r : 8'd0;
            err_d       = err_d | core_q[DIGIT_W+1];

            if (in_last) begin
                state_d = IDLE;
                rem_d   = 8'd0;
                idx_d   = '0;
            end else begin
                state_d = ACTIVE;
                rem_d   = core_r;
                unique case (state_q)
                    IDLE:   idx_d = CNT_W'(1);
                    ACTIVE: begin
                        idx_d = idx_q + CNT_W'(1);
                        // Index wrap means out_idx can no longer identify the digit.
                        err_d = err_d | (&idx_q);
                    end
                    default: idx_d = '0;
                endcase
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_rem_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= 8'd0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_q_q     <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_rem_q   <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_q_q     <= out_q_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_rem_q   <= out_rem_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_rem   = out_rem_q;
    assign err_ovf   = err_q;

endmodule
